dplbuf_mm_arbiter: RTL and testbench
====================================

Name: dplbuf_mm_arbiter

Overview:
- Shares the single 14-bit-address / 64-bit-data MM port of the DPL buffer address decoder between NREQ requesters (e.g. host register path, readout DMA, BIST).
- Arbitration is round-robin. Writes are posted. At most one read is outstanding.
- A read timeout guarantees every granted read is completed, including reads to unmapped or stalled buffers.
- Sits directly upstream of the decoder; all MM outputs are registered.

Parameters:
- NREQ, 2, number of requesters (2..8).
- RD_TIMEOUT, 64, cycles to wait for mm_rd_data_v before forcing an error completion (>=8).
- TOW, 8, width of the timeout counter; must satisfy 2**TOW > RD_TIMEOUT.

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- req_wr  in  NREQ  per-requester write request; level, held until gnt
- req_rd  in  NREQ  per-requester read request; level, held until gnt
- req_addr  in  NREQ*14  per-requester address; slice i = [14*i+13:14*i]
- req_wdata  in  NREQ*64  per-requester write data
- gnt  out  NREQ  one-cycle accept pulse, one-hot or zero
- rsp_rdata  out  64  read completion data, shared by all requesters
- rsp_v  out  NREQ  one-hot read completion strobe
- rsp_err  out  1  qualifies rsp_v; 1 means timeout
- mm_wr_en  out  1  to decoder iMM_WR_EN
- mm_rd_en  out  1  to decoder iMM_RD_EN
- mm_addr  out  14  to decoder iMM_ADDR
- mm_wr_data  out  64  to decoder iMM_WR_DATA
- mm_rd_data  in  64  from decoder oMM_RD_DATA
- mm_rd_data_v  in  1  from decoder oMM_RD_DATA_V

Behaviour:
- Clock and reset: reset rst_n, asynchronous, active-low; clock clk.
- Reset values:
  - All outputs 0.
  - State IDLE, rr pointer 0, timeout count 0.
- States:
  - IDLE: arbitrate every cycle.
  - WAIT_RD: one read outstanding; no grants issued.
- Arbitration (IDLE only):
  - Eligible(i) = req_wr[i] | req_rd[i].
  - Winner = first eligible index at or after ptr, wrapping modulo NREQ.
  - gnt[winner] pulses combinationally in the same cycle.
  - ptr <= winner+1, wrapping to 0 after NREQ-1.
- Write grant:
  - Next cycle: mm_wr_en=1, mm_addr and mm_wr_data from the winner's slices; stay in IDLE.
  - Write throughput is one per cycle.
- Read grant (winner has req_rd and not req_wr):
  - Next cycle: mm_rd_en=1 and mm_addr driven; go to WAIT_RD; latch owner index; clear the timeout counter.
- Same requester asserting req_wr and req_rd together:
  - The write is served first.
  - The read stays pending and competes again in the next round-robin turn.
- mm_wr_en and mm_rd_en are single-cycle pulses and are never asserted together.
- mm_addr and mm_wr_data hold their last value when idle.
- WAIT_RD, data return:
  - On mm_rd_data_v=1: next cycle rsp_v[owner]=1, rsp_rdata=mm_rd_data, rsp_err=0; return to IDLE.
  - Arbitration resumes in the same cycle rsp_v is high.
- WAIT_RD, timeout:
  - The counter increments each cycle without mm_rd_data_v.
  - When it reaches RD_TIMEOUT-1 without valid: next cycle rsp_v[owner]=1, rsp_err=1, rsp_rdata={32'hBAD0_BAD0,18'b0,owner_addr}; return to IDLE.
  - A late mm_rd_data_v arriving in IDLE is dropped.
- If mm_rd_data_v and timeout expiry occur in the same cycle, the data wins and rsp_err=0.
- mm_rd_data_v outside WAIT_RD is ignored.
- Requester rules:
  - A requester deasserting its request before gnt is legal; nothing is issued for it.
  - Address and data must be stable while the request is held.
- Reset mid-read: the outstanding read is abandoned and no rsp_v is generated.
- Latency: read gnt to rsp_v = decoder read latency + 2 cycles. The decoder's nominal read latency is 3 cycles, giving 5.

Optional Feature:
- Macro: DPLBUF_MM_ARB_STATS_EN.
- Defined:
  - Adds output stat_grants (NREQ*32): per-requester saturating grant counters, incremented on each gnt.
  - Adds output stat_timeouts (16): saturating count of timeout completions.
  - Adds input stat_clr (1): synchronous clear of all counters; a grant in the same cycle as the clear is not counted.
- Not defined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package dplbuf_mm_pkg holds:
  - MM_AW=14 and MM_DW=64.
  - typedef enum logic [0:0] {IDLE, WAIT_RD} arb_state_e.
  - The timeout data pattern constant TO_PATTERN=32'hBAD0_BAD0.
- Sub-module rr_arbiter (parameter N): inputs eligible vector and ptr; outputs one-hot winner and encoded index. Pure combinational, reusable elsewhere.

Test Plan:
- Single write: req_wr[0] with addr 14'h0405, data 64'h1122_3344_5566_7788 -> gnt[0] in the same cycle; next cycle mm_wr_en=1 with that addr/data; no rsp_v.
- Single read: req_rd[1] addr 14'h2C10; decoder model returns 64'hCAFE with 3-cycle latency -> rsp_v=2'b10, rsp_rdata=64'hCAFE, rsp_err=0, exactly 5 cycles after gnt.
- Fairness: both requesters hold req_wr continuously for 8 cycles -> gnt alternates 01,10,01,... with 4 grants each and mm_wr_en high every cycle after the first.
- Timeout: read to 14'h3000 with no mm_rd_data_v -> after RD_TIMEOUT cycles rsp_err=1, rsp_rdata=64'hBAD0_BAD0_0000_3000; a late valid in IDLE produces no rsp_v.
- Read blocking: req_rd[0] outstanding while req_wr[1] is asserted -> gnt[1] is held off until the cycle of rsp_v[0].
- Reset mid-read: rst_n low during WAIT_RD -> all outputs 0 and no completion after release. With DPLBUF_MM_ARB_STATS_EN defined: 3 grants -> stat_grants slice = 3; stat_clr returns it to 0.

Source files
------------

// File: rtl/dplbuf_mm_arbiter_pkg.sv
// Shared types and constants for the DPL buffer MM arbiter: bus widths,
// FSM state encoding and the data pattern returned on a read timeout.
package dplbuf_mm_pkg;

    localparam int MM_AW = 14;
    localparam int MM_DW = 64;

    localparam logic [31:0] TO_PATTERN = 32'hBAD0_BAD0;

    typedef enum logic [0:0] {
        IDLE,
        WAIT_RD
    } arb_state_e;

endpackage

// File: rtl/dplbuf_mm_arbiter_if.sv
// Requester-side and decoder-side signal bundle of the MM arbiter.
// slave = arbiter view, master = requesters plus decoder (testbench) view.
interface dplbuf_mm_arbiter_if
    import dplbuf_mm_pkg::*;
#(
    parameter int NREQ = 2
);

    // Requests are levels held until the one-cycle gnt pulse; gnt is the only
    // accept. rsp_v / mm_*_en are single-cycle strobes with no backpressure.
    logic [NREQ-1:0]       req_wr;
    logic [NREQ-1:0]       req_rd;
    logic [NREQ*MM_AW-1:0] req_addr;
    logic [NREQ*MM_DW-1:0] req_wdata;
    logic [NREQ-1:0]       gnt;
    logic [MM_DW-1:0]      rsp_rdata;
    logic [NREQ-1:0]       rsp_v;
    logic                  rsp_err;

    logic                  mm_wr_en;
    logic                  mm_rd_en;
    logic [MM_AW-1:0]      mm_addr;
    logic [MM_DW-1:0]      mm_wr_data;
    logic [MM_DW-1:0]      mm_rd_data;
    logic                  mm_rd_data_v;

    modport slave (
        input  req_wr, req_rd, req_addr, req_wdata, mm_rd_data, mm_rd_data_v,
        output gnt, rsp_rdata, rsp_v, rsp_err, mm_wr_en, mm_rd_en, mm_addr, mm_wr_data
    );

    modport master (
        output req_wr, req_rd, req_addr, req_wdata, mm_rd_data, mm_rd_data_v,
        input  gnt, rsp_rdata, rsp_v, rsp_err, mm_wr_en, mm_rd_en, mm_addr, mm_wr_data
    );

endinterface

// File: rtl/dplbuf_mm_arbiter_rr.sv
// Combinational round-robin pick: first eligible index at or after i_ptr,
// wrapping modulo N. Returns one-hot and encoded winner.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_elig,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_win_oh,
    output logic [IW-1:0] o_win_idx,
    output logic          o_any
);

    function automatic int rot(input int p, input int k);
        int j;
        j = p + k;
        return (j >= N) ? j - N : j;
    endfunction

    always_comb begin
        o_win_oh  = '0;
        o_win_idx = '0;
        o_any     = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!o_any && i_elig[rot(int'(i_ptr), k)]) begin
                o_any                        = 1'b1;
                o_win_oh[rot(int'(i_ptr), k)] = 1'b1;
                o_win_idx                    = IW'(rot(int'(i_ptr), k));
            end
        end
    end

endmodule

// File: rtl/dplbuf_mm_arbiter.sv
// Round-robin arbiter sharing the decoder MM port: posted writes, one read
// outstanding with timeout. Optional counters under DPLBUF_MM_ARB_STATS_EN.
module dplbuf_mm_arbiter
    import dplbuf_mm_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int RD_TIMEOUT = 64,
    parameter int TOW        = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    dplbuf_mm_arbiter_if.slave bus,
`ifdef DPLBUF_MM_ARB_STATS_EN
    input  logic               stat_clr,
    output logic [NREQ*32-1:0] stat_grants,
    output logic [15:0]        stat_timeouts,
`endif
    output arb_state_e         o_dbg_state
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e       r_state;
    logic [IW-1:0]    r_ptr;
    logic [IW-1:0]    r_owner;
    logic [MM_AW-1:0] r_owner_addr;
    logic [TOW-1:0]   r_to_cnt;
    logic             r_mm_wr_en;
    logic             r_mm_rd_en;
    logic [MM_AW-1:0] r_mm_addr;
    logic [MM_DW-1:0] r_mm_wr_data;
    logic [NREQ-1:0]  r_rsp_v;
    logic             r_rsp_err;
    logic [MM_DW-1:0] r_rsp_rdata;

    logic [NREQ-1:0]  w_elig;
    logic [NREQ-1:0]  w_win_oh;
    logic [NREQ-1:0]  w_gnt;
    logic [NREQ-1:0]  w_owner_oh;
    logic [IW-1:0]    w_win_idx;
    logic [IW-1:0]    w_ptr_nxt;
    logic             w_any;
    logic             w_grant;
    logic             w_sel_wr;
    logic             w_to_hit;
    logic             w_to_fire;
    logic [MM_AW-1:0] w_sel_addr;
    logic [MM_DW-1:0] w_sel_wdata;
    logic [MM_DW-1:0] w_to_data;

    assign w_elig = bus.req_wr | bus.req_rd;

    rr_arbiter #(.N(NREQ), .IW(IW)) u_rr (
        .i_elig    (w_elig),
        .i_ptr     (r_ptr),
        .o_win_oh  (w_win_oh),
        .o_win_idx (w_win_idx),
        .o_any     (w_any)
    );

    // A requester with both wr and rd set is granted its write first.
    assign w_grant     = (r_state == IDLE) && w_any;
    assign w_gnt       = w_grant ? w_win_oh : '0;
    assign w_sel_wr    = bus.req_wr[w_win_idx];
    assign w_sel_addr  = bus.req_addr[w_win_idx*MM_AW +: MM_AW];
    assign w_sel_wdata = bus.req_wdata[w_win_idx*MM_DW +: MM_DW];
    assign w_ptr_nxt   = (w_win_idx == IW'(NREQ - 1)) ? '0 : w_win_idx + 1'b1;
    assign w_owner_oh  = NREQ'(1) << r_owner;
    assign w_to_hit    = (r_to_cnt == TOW'(RD_TIMEOUT - 1));
    assign w_to_fire   = (r_state == WAIT_RD) && !bus.mm_rd_data_v && w_to_hit;
    assign w_to_data   = {TO_PATTERN, {(MM_DW - 32 - MM_AW){1'b0}}, r_owner_addr};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_ptr        <= '0;
            r_owner      <= '0;
            r_owner_addr <= '0;
            r_to_cnt     <= '0;
            r_mm_wr_en   <= 1'b0;
            r_mm_rd_en   <= 1'b0;
            r_mm_addr    <= '0;
            r_mm_wr_data <= '0;
            r_rsp_v      <= '0;
            r_rsp_err    <= 1'b0;
            r_rsp_rdata  <= '0;
        end else begin
            r_mm_wr_en <= 1'b0;
            r_mm_rd_en <= 1'b0;
            r_rsp_v    <= '0;
            r_rsp_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_ptr     <= w_ptr_nxt;
                        r_mm_addr <= w_sel_addr;
                        if (w_sel_wr) begin
                            r_mm_wr_en   <= 1'b1;
                            r_mm_wr_data <= w_sel_wdata;
                        end else begin
                            r_mm_rd_en   <= 1'b1;
                            r_owner      <= w_win_idx;
                            r_owner_addr <= w_sel_addr;
                            r_to_cnt     <= '0;
                            r_state      <= WAIT_RD;
                        end
                    end
                end
                WAIT_RD: begin
                    // Returned data takes priority over a coincident timeout.
                    if (bus.mm_rd_data_v) begin
                        r_rsp_v     <= w_owner_oh;
                        r_rsp_rdata <= bus.mm_rd_data;
                        r_state     <= IDLE;
                    end else if (w_to_hit) begin
                        r_rsp_v     <= w_owner_oh;
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= w_to_data;
                        r_state     <= IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.gnt        = w_gnt;
    assign bus.mm_wr_en   = r_mm_wr_en;
    assign bus.mm_rd_en   = r_mm_rd_en;
    assign bus.mm_addr    = r_mm_addr;
    assign bus.mm_wr_data = r_mm_wr_data;
    assign bus.rsp_v      = r_rsp_v;
    assign bus.rsp_err    = r_rsp_err;
    assign bus.rsp_rdata  = r_rsp_rdata;
    assign o_dbg_state    = r_state;

`ifdef DPLBUF_MM_ARB_STATS_EN
    logic [NREQ-1:0][31:0] r_stat_grants;
    logic [15:0]           r_stat_timeouts;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_grants   <= '0;
            r_stat_timeouts <= '0;
        end else if (stat_clr) begin
            r_stat_grants   <= '0;
            r_stat_timeouts <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (w_gnt[i] && (r_stat_grants[i] != 32'hFFFF_FFFF)) begin
                    r_stat_grants[i] <= r_stat_grants[i] + 32'd1;
                end
            end
            if (w_to_fire && (r_stat_timeouts != 16'hFFFF)) begin
                r_stat_timeouts <= r_stat_timeouts + 16'd1;
            end
        end
    end

    assign stat_grants   = r_stat_grants;
    assign stat_timeouts = r_stat_timeouts;
`endif

endmodule

// File: tb/tb_dplbuf_mm_arbiter.sv
// Self-checking bench for dplbuf_mm_arbiter with a decoder read model and
// write/read scoreboards. Stats checks compile only with DPLBUF_MM_ARB_STATS_EN.
module tb_dplbuf_mm_arbiter;
    import dplbuf_mm_pkg::*;

    localparam int NREQ       = 2;
    localparam int RD_TIMEOUT = 64;
    localparam int TOW        = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    dplbuf_mm_arbiter_if #(.NREQ(NREQ)) bus ();
    arb_state_e dbg_state;

`ifdef DPLBUF_MM_ARB_STATS_EN
    logic               stat_clr;
    logic [NREQ*32-1:0] stat_grants;
    logic [15:0]        stat_timeouts;
`endif

    dplbuf_mm_arbiter #(.NREQ(NREQ), .RD_TIMEOUT(RD_TIMEOUT), .TOW(TOW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus.slave),
`ifdef DPLBUF_MM_ARB_STATS_EN
        .stat_clr      (stat_clr),
        .stat_grants   (stat_grants),
        .stat_timeouts (stat_timeouts),
`endif
        .o_dbg_state   (dbg_state)
    );

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboards ----------------
    logic [MM_AW+MM_DW-1:0]  wexp_q[$];
    logic [NREQ+MM_DW:0]     rexp_q[$];

    always @(negedge clk) begin
        if (rst_n) begin
            check("mm_excl", bus.mm_wr_en & bus.mm_rd_en, 1'b0);
            if (bus.mm_wr_en) begin
                check("wr_pending", wexp_q.size() != 0, 1'b1);
                if (wexp_q.size() != 0)
                    check("wr_addr_data", {bus.mm_addr, bus.mm_wr_data}, wexp_q.pop_front());
            end
            if (bus.rsp_v != '0) begin
                check("rsp_pending", rexp_q.size() != 0, 1'b1);
                if (rexp_q.size() != 0)
                    check("rsp_v_err_data", {bus.rsp_v, bus.rsp_err, bus.rsp_rdata}, rexp_q.pop_front());
            end
        end
    end

    // ---------------- decoder read model ----------------
    int          dec_lat;
    logic [63:0] dec_rdata;
    int          dec_cnt;

    initial begin
        bus.mm_rd_data_v = 1'b0;
        bus.mm_rd_data   = '0;
        dec_cnt          = 0;
        forever begin
            @(negedge clk);
            bus.mm_rd_data_v = 1'b0;
            if (dec_cnt > 0) begin
                dec_cnt--;
                if (dec_cnt == 0) begin
                    bus.mm_rd_data_v = 1'b1;
                    bus.mm_rd_data   = dec_rdata;
                end
            end
            if (bus.mm_rd_en) dec_cnt = dec_lat;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic wr, input logic rd,
                           input logic [13:0] a, input logic [63:0] d);
        bus.req_wr[i]             = wr;
        bus.req_rd[i]             = rd;
        bus.req_addr[i*14 +: 14]  = a;
        bus.req_wdata[i*64 +: 64] = d;
    endtask

    task automatic wait_rsp(input int limit, output int at);
        at = -1;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (bus.rsp_v != '0) begin
                at = cyc;
                break;
            end
        end
        check("rsp_seen", at >= 0, 1'b1);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        int g, at, cnt0, cnt1;
        logic got;

        rst_n         = 1'b0;
        bus.req_wr    = '0;
        bus.req_rd    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        dec_lat       = 3;
        dec_rdata     = '0;
`ifdef DPLBUF_MM_ARB_STATS_EN
        stat_clr      = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_gnt", bus.gnt, 2'b00);
        check("rst_rsp_v", bus.rsp_v, 2'b00);
        check("rst_rsp_err", bus.rsp_err, 1'b0);
        check("rst_rsp_rdata", bus.rsp_rdata, 64'h0);
        check("rst_wr_en", bus.mm_wr_en, 1'b0);
        check("rst_rd_en", bus.mm_rd_en, 1'b0);
        check("rst_addr", bus.mm_addr, 14'h0);
        check("rst_wdata", bus.mm_wr_data, 64'h0);
        check("rst_state", dbg_state, IDLE);
        step();
        rst_n = 1'b1;
        step();

        // single write
        set_req(0, 1'b1, 1'b0, 14'h0405, 64'h1122_3344_5566_7788);
        @(negedge clk);
        check("w1_gnt", bus.gnt, 2'b01);
        wexp_q.push_back({14'h0405, 64'h1122_3344_5566_7788});
        step();
        set_req(0, 1'b0, 1'b0, 14'h0, 64'h0);
        @(negedge clk);
        check("w1_wr_en", bus.mm_wr_en, 1'b1);
        check("w1_no_rsp", bus.rsp_v, 2'b00);

        // single read, 3-cycle decoder
        step();
        dec_lat   = 3;
        dec_rdata = 64'hCAFE;
        set_req(1, 1'b0, 1'b1, 14'h2C10, 64'h0);
        @(negedge clk);
        check("r1_gnt", bus.gnt, 2'b10);
        g = cyc;
        rexp_q.push_back({2'b10, 1'b0, 64'hCAFE});
        step();
        set_req(1, 1'b0, 1'b0, 14'h0, 64'h0);
        wait_rsp(20, at);
        check("r1_latency", at - g, 5);

        // fairness: both requesters write continuously
        step();
        cnt0 = 0;
        cnt1 = 0;
        for (int k = 0; k < 8; k++) begin
            set_req(0, 1'b1, 1'b0, 14'(14'h0100 + k), 64'hA0 + 64'(k));
            set_req(1, 1'b1, 1'b0, 14'(14'h0200 + k), 64'hB0 + 64'(k));
            @(negedge clk);
            check("fair_gnt", bus.gnt, (k % 2 == 0) ? 2'b01 : 2'b10);
            if (k % 2 == 0) wexp_q.push_back({14'(14'h0100 + k), 64'hA0 + 64'(k)});
            else            wexp_q.push_back({14'(14'h0200 + k), 64'hB0 + 64'(k)});
            if (k > 0) check("fair_wr_en", bus.mm_wr_en, 1'b1);
            cnt0 += int'(bus.gnt[0]);
            cnt1 += int'(bus.gnt[1]);
            step();
        end
        bus.req_wr = '0;
        @(negedge clk);
        check("fair_last_wr", bus.mm_wr_en, 1'b1);
        check("fair_cnt0", cnt0, 4);
        check("fair_cnt1", cnt1, 4);

        // read blocks a later write until completion
        step();
        dec_rdata = 64'h5555_0000_1234;
        set_req(0, 1'b0, 1'b1, 14'h0222, 64'h0);
        @(negedge clk);
        check("blk_rd_gnt", bus.gnt, 2'b01);
        rexp_q.push_back({2'b01, 1'b0, 64'h5555_0000_1234});
        step();
        set_req(0, 1'b0, 1'b0, 14'h0, 64'h0);
        set_req(1, 1'b1, 1'b0, 14'h0333, 64'hDD);
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.rsp_v != '0) begin
                check("blk_gnt_at_rsp", bus.gnt, 2'b10);
                wexp_q.push_back({14'h0333, 64'hDD});
                got = 1'b1;
                break;
            end else begin
                check("blk_hold", bus.gnt, 2'b00);
            end
        end
        check("blk_seen", got, 1'b1);
        step();
        set_req(1, 1'b0, 1'b0, 14'h0, 64'h0);

        // same requester wr+rd: write first, then read
        step();
        dec_rdata = 64'h77;
        set_req(1, 1'b1, 1'b1, 14'h0444, 64'h99);
        @(negedge clk);
        check("wr_rd_first", bus.gnt, 2'b10);
        wexp_q.push_back({14'h0444, 64'h99});
        step();
        bus.req_wr[1] = 1'b0;
        @(negedge clk);
        check("wr_rd_second", bus.gnt, 2'b10);
        check("wr_rd_wr_en", bus.mm_wr_en, 1'b1);
        rexp_q.push_back({2'b10, 1'b0, 64'h77});
        step();
        set_req(1, 1'b0, 1'b0, 14'h0, 64'h0);
        @(negedge clk);
        check("wr_rd_rd_en", bus.mm_rd_en, 1'b1);
        wait_rsp(20, at);

        // data arriving on the expiry cycle wins
        step();
        dec_lat   = RD_TIMEOUT - 1;
        dec_rdata = 64'hD00D;
        set_req(0, 1'b0, 1'b1, 14'h0555, 64'h0);
        @(negedge clk);
        check("tie_gnt", bus.gnt, 2'b01);
        g = cyc;
        rexp_q.push_back({2'b01, 1'b0, 64'hD00D});
        step();
        set_req(0, 1'b0, 1'b0, 14'h0, 64'h0);
        wait_rsp(RD_TIMEOUT + 10, at);
        check("tie_latency", at - g, RD_TIMEOUT + 1);

        // timeout, then a late valid in IDLE is dropped
        step();
        dec_lat   = RD_TIMEOUT + 6;
        dec_rdata = 64'hDEAD;
        set_req(1, 1'b0, 1'b1, 14'h3000, 64'h0);
        @(negedge clk);
        check("to_gnt", bus.gnt, 2'b10);
        g = cyc;
        rexp_q.push_back({2'b10, 1'b1, 64'hBAD0_BAD0_0000_3000});
        step();
        set_req(1, 1'b0, 1'b0, 14'h0, 64'h0);
        wait_rsp(RD_TIMEOUT + 10, at);
        check("to_latency", at - g, RD_TIMEOUT + 1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("late_drop", bus.rsp_v, 2'b00);
        end

        // reset during an outstanding read
        step();
        dec_lat = 3;
        set_req(0, 1'b0, 1'b1, 14'h0666, 64'h0);
        @(negedge clk);
        check("rr_gnt", bus.gnt, 2'b01);
        step();
        set_req(0, 1'b0, 1'b0, 14'h0, 64'h0);
        rst_n = 1'b0;
        #1;
        check("rr_rd_en", bus.mm_rd_en, 1'b0);
        check("rr_addr", bus.mm_addr, 14'h0);
        check("rr_wdata", bus.mm_wr_data, 64'h0);
        check("rr_rdata", bus.rsp_rdata, 64'h0);
        check("rr_state", dbg_state, IDLE);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("rr_no_rsp", bus.rsp_v, 2'b00);
        end

`ifdef DPLBUF_MM_ARB_STATS_EN
        check("st_rst_timeouts", stat_timeouts, 16'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            set_req(0, 1'b1, 1'b0, 14'(14'h0700 + k), 64'hE0 + 64'(k));
            @(negedge clk);
            check("st_gnt", bus.gnt, 2'b01);
            wexp_q.push_back({14'(14'h0700 + k), 64'hE0 + 64'(k)});
        end
        step();
        set_req(0, 1'b0, 1'b0, 14'h0, 64'h0);
        @(negedge clk);
        check("st_grants0", stat_grants[31:0], 32'd3);
        check("st_grants1", stat_grants[63:32], 32'd0);
        step();
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        @(negedge clk);
        check("st_clr", stat_grants[31:0], 32'd0);
`endif

        repeat (4) step();
        check("wq_empty", wexp_q.size(), 0);
        check("rq_empty", rexp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
